// File: rtl/booth_multiplier_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier.
package booth_multiplier_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Booth selector {Q[0], Q_1}
    localparam logic [1:0] BOOTH_NOP0 = 2'b00;
    localparam logic [1:0] BOOTH_ADD  = 2'b01;
    localparam logic [1:0] BOOTH_SUB  = 2'b10;
    localparam logic [1:0] BOOTH_NOP1 = 2'b11;

    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/booth_multiplier_adder.sv
// Plain ripple-carry adder; the final carry is not produced (modular sum).
module adder #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum
);

    always_comb begin
        logic c;
        o_sum = '0;
        c     = i_cin;
        for (int i = 0; i < WIDTH; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ c;
            c        = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
        end
    end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed radix-2 Booth multiplier, one step per cycle,
// valid/ready on both sides.
module booth_multiplier
    import booth_multiplier_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH:0]   r_m;
    logic [WIDTH:0]   r_nm;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q;
    logic             r_q1;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]     w_m_ext;
    logic [WIDTH:0]     w_nm;
    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH+1:0] w_next;

    assign w_m_ext = {a[WIDTH-1], a};

    // Negated multiplicand formed once at load: ~M + 1
    adder #(.WIDTH(WIDTH + 1)) u_neg (
        .i_a   (~w_m_ext),
        .i_b   ((WIDTH + 1)'(1)),
        .i_cin (1'b0),
        .o_sum (w_nm)
    );

    always_comb begin
        w_addend = '0;
        unique case ({r_q[0], r_q1})
            BOOTH_ADD:  w_addend = r_m;
            BOOTH_SUB:  w_addend = r_nm;
            BOOTH_NOP0: w_addend = '0;
            BOOTH_NOP1: w_addend = '0;
            default:    w_addend = '0;
        endcase
    end

    adder #(.WIDTH(WIDTH + 1)) u_acc (
        .i_a   (r_acc),
        .i_b   (w_addend),
        .i_cin (1'b0),
        .o_sum (w_sum)
    );

    // Arithmetic right shift of {ACC, Q, Q_1}
    assign w_next = {w_sum[WIDTH], w_sum, r_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            r_m       <= '0;
            r_nm      <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_cnt     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_m      <= w_m_ext;
                        r_nm     <= w_nm;
                        r_acc    <= '0;
                        r_q      <= b;
                        r_q1     <= 1'b0;
                        r_cnt    <= '0;
                        in_ready <= 1'b0;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_next[2*WIDTH+1:WIDTH+1];
                    r_q   <= w_next[WIDTH:1];
                    r_q1  <= w_next[0];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        product   <= w_next[2*WIDTH:1];
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier (WIDTH=4).
module tb_booth_multiplier;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] product;

    int tests = 0;
    int fails = 0;

    booth_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x,
                                               input logic [W-1:0] y);
        int sx;
        int sy;
        int p;
        sx = int'($signed(x));
        sy = int'($signed(y));
        p  = sx * sy;
        return p[2*W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation; caller is positioned just after a rising edge.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input int stall, output logic [2*W-1:0] p,
                          output int lat, output bit to);
        int n;
        to  = 1'b0;
        lat = 0;
        p   = '0;
        n   = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            to = 1'b1;
            return;
        end
        a        = x;
        b        = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            to = 1'b1;
            return;
        end
        for (int i = 0; i < stall; i++) tick();
        p         = product;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0) begin
            fails++;
            $display("FAIL reset: in_ready=%b out_valid=%b product=%h want 1 0 00",
                     in_ready, out_valid, product);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0]   xs [4] = '{4'b0111, 4'b1000, 4'b1000, 4'b0000};
        logic [W-1:0]   ys [4] = '{4'b1101, 4'b1000, 4'b0111, 4'b1011};
        logic [2*W-1:0] ex [4] = '{8'b11101011, 8'b01000000, 8'b11001000, 8'b00000000};
        logic [2*W-1:0] p;
        int lat;
        bit to;
        for (int i = 0; i < 4; i++) begin
            run_op(xs[i], ys[i], 0, p, lat, to);
            tests++;
            if (to) begin
                fails++;
                $display("FAIL directed%0d timeout", i);
                continue;
            end
            tests++;
            if (lat !== W) begin
                fails++;
                $display("FAIL latency%0d: got %0d want %0d", i, lat, W);
            end
            tests++;
            if (p !== ex[i] || p !== ref_mul(xs[i], ys[i])) begin
                fails++;
                $display("FAIL directed%0d: got %h want %h", i, p, ex[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        logic [2*W-1:0] p;
        int lat;
        bit to;
        a        = 4'd3;
        b        = 4'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        tests++;
        if (!out_valid) begin
            fails++;
            $display("FAIL bp_timeout: out_valid=%b want 1", out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            a        = W'($urandom);
            b        = W'($urandom);
            tick();
            tests++;
            if (out_valid !== 1'b1 || product !== 8'b00001111 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d: ov=%b prod=%h ir=%b want 1 0f 0",
                         i, out_valid, product, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 8'b00001111) begin
            fails++;
            $display("FAIL bp_release: ov=%b ir=%b prod=%h want 0 1 0f",
                     out_valid, in_ready, product);
        end
        run_op(4'd2, 4'd3, 2, p, lat, to);
        tests++;
        if (to || p !== 8'd6) begin
            fails++;
            $display("FAIL bp_next: got %h to=%b want 06", p, to);
        end
    endtask

    task automatic test_reset_mid();
        logic [2*W-1:0] p;
        int lat;
        bit to;
        a        = 4'd7;
        b        = 4'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0) begin
            fails++;
            $display("FAIL reset_mid: ir=%b ov=%b prod=%h want 1 0 00",
                     in_ready, out_valid, product);
        end
        tick();
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_abort: ov=%b want 0", out_valid);
        end
        run_op(4'd2, 4'b1111, 0, p, lat, to);
        tests++;
        if (to || p !== 8'b11111110 || lat !== W) begin
            fails++;
            $display("FAIL reset_mid_next: got %h lat=%0d want fe lat=%0d", p, lat, W);
        end
    endtask

    task automatic test_sweep();
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        logic [2*W-1:0] p;
        int lat;
        bit to;
        int errs = 0;
        for (int i = 0; i < 256; i++) begin
            x = W'(i >> 4);
            y = W'(i);
            run_op(x, y, int'($urandom_range(0, 3)), p, lat, to);
            tests++;
            if (to || p !== ref_mul(x, y)) begin
                fails++;
                errs++;
                if (errs < 10)
                    $display("FAIL sweep a=%h b=%h: got %h want %h to=%b",
                             x, y, p, ref_mul(x, y), to);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/booth_multiplier.md
Name: booth_multiplier

Overview:
- Sequential signed radix-2 Booth multiplier for two's-complement operands.
- Consumes one ripple adder instance, WIDTH+1 bits wide, and uses it for every partial-product add or subtract.
- Takes operands over a valid/ready input handshake and returns a 2*WIDTH-bit signed product over a valid/ready output handshake.
- Sits directly downstream of operand sources and feeds signed arithmetic consumers (accumulators, ALU result mux).

Parameters:
- WIDTH, 4, operand width in bits (≥2); product width is 2*WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand, signed two's complement.
- b  input  WIDTH  multiplier, signed two's complement.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  signed product a*b.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - On a clk edge with rst=1: state=IDLE, in_ready=1, out_valid=0, product=0, all internal registers=0.
  - rst mid-operation aborts the operation with no output; the result is discarded.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready at edge T, load the registers below, then go to CALC.
    - M = sign-extend(a) to WIDTH+1.
    - NM = -M (two's complement, WIDTH+1 bits).
    - ACC = 0 (WIDTH+1 bits).
    - Q = b, Q_1 = 0, count = 0.
  - CALC: in_ready=0. Each cycle, select on {Q[0],Q_1}:
    - 01: ACC + M
    - 10: ACC + NM
    - 00 or 11: ACC unchanged
    - Then arithmetic shift right {ACC,Q,Q_1} by 1, with the ACC MSB replicated.
    - count increments each cycle.
    - On the cycle where count==WIDTH-1, the step is performed and the state moves to DONE.
    - product <= {ACC,Q}[2*WIDTH-1:0] (post-shift value) and out_valid <= 1.
  - DONE: out_valid=1, product held stable. On out_valid&out_ready, clear out_valid and go to IDLE; in_ready=1 the following cycle.
- Latency:
  - Operand handshake at edge T gives out_valid=1 after edge T+WIDTH.
  - Throughput is one product per WIDTH+2 cycles minimum.
  - Input and output never overlap; in_ready=0 in CALC and DONE.
- Arithmetic:
  - All additions use the adder at WIDTH+1 bits. Its overflow/carry output is ignored (modular arithmetic).
  - The WIDTH+1 accumulator makes a = -2^(WIDTH-1) safe; NM of the most negative value must be representable.
  - The result is exact for all operand pairs, including (-2^(WIDTH-1))², which fits in 2*WIDTH signed bits.
- Boundaries:
  - in_valid is ignored outside IDLE. a and b are sampled only at the handshake edge; later changes are ignored.
  - out_ready held low: product and out_valid stay stable indefinitely.
  - out_ready high at the same edge DONE is entered: no effect. The transfer occurs at the next edge.
  - product retains its last value after the transfer until the next completion.

Decomposition:
- Shared package:
  - state typedef {IDLE, CALC, DONE}.
  - Booth decode constants for the 2-bit selector.
  - count width = clog2(WIDTH).
- Sub-module: reuse the existing `adder` with #(.WIDTH(WIDTH+1)).
  - One instance for the ACC update; the operand mux selects M, NM or 0.
  - One further instance is permitted to form NM at load (~M + 1 via adding 1).
- No other sub-modules.

Test Plan:
- All cases below use WIDTH=4.
- a=0111 (7), b=1101 (-3), handshake at T -> out_valid at T+4, product=11101011 (-21).
- a=1000 (-8), b=1000 (-8) -> product=01000000 (64); checks most-negative handling.
- a=1000 (-8), b=0111 (7) -> product=11001000 (-56). Then a=0000, b=1011 -> product=00000000.
- Backpressure: out_ready=0 for 10 cycles after completion of 3*5 -> out_valid and product=00001111 stable throughout; in_ready=0 throughout; in_valid pulses ignored. Release -> IDLE, next op accepted.
- Reset mid-CALC (rst=1 two cycles after handshake) -> next edge in_ready=1, out_valid=0, product=0. The following op 2*(-1) yields 11111110.
- Exhaustive sweep of all 256 a,b pairs with random out_ready stalls -> every product equals the signed reference product, one output per accepted input, in order.
